// File: rtl/alu_cmp_pipe_fu.sv
// Pipelined ALU/branch unit: LAT-cycle execute into an in-order OBUF_DEPTH result queue.
// Issue is stalled by fu_busy once ops in flight plus queued results reach OBUF_DEPTH.
module alu_cmp_pipe_fu #(
   parameter int LAT        = 2,
   parameter int OBUF_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         branch_mispredict,
   input  logic [171:0] input_data,
   input  logic         fu_start,
   input  logic         cdb_ack,
   output logic [205:0] output_data,
   output logic         fu_busy,
   output logic         fu_done
);
   localparam int RES_W = 206;
   localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   if (LAT < 1 || LAT > 4) begin : g_bad_lat
      $error("alu_cmp_pipe_fu: LAT must be in 1..4");
   end

   logic [31:0] w_instr, w_pc, w_a_v, w_b_v, w_order;
   logic [5:0]  w_pd_s;
   logic [4:0]  w_rob;
   logic        w_pred;
   assign {w_instr, w_pc, w_a_v, w_b_v, w_pd_s, w_rob, w_pred, w_order} = input_data;

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [31:0] w_i_imm, w_u_imm, w_b_imm, w_j_imm, w_pc_4, w_op_b, w_sra;
   logic [4:0]  w_shamt;
   assign w_opc   = w_instr[6:0];
   assign w_f3    = w_instr[14:12];
   assign w_i_imm = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_u_imm = {w_instr[31:12], 12'h000};
   assign w_b_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_j_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
   assign w_pc_4  = w_pc + 32'd4;
   assign w_op_b  = (w_opc == OP_REG) ? w_b_v : w_i_imm;
   assign w_shamt = w_op_b[4:0];
   assign w_sra   = $signed(w_a_v) >>> w_shamt;

   logic [31:0] w_alu;
   always_comb begin
      w_alu = '0;
      case (w_f3)
         3'b000:  w_alu = (w_opc == OP_REG && w_instr[30]) ? w_a_v - w_op_b : w_a_v + w_op_b;
         3'b001:  w_alu = w_a_v << w_shamt;
         3'b010:  w_alu = {31'b0, $signed(w_a_v) < $signed(w_op_b)};
         3'b011:  w_alu = {31'b0, w_a_v < w_op_b};
         3'b100:  w_alu = w_a_v ^ w_op_b;
         3'b101:  w_alu = w_instr[30] ? w_sra : (w_a_v >> w_shamt);
         3'b110:  w_alu = w_a_v | w_op_b;
         default: w_alu = w_a_v & w_op_b;
      endcase
   end

   logic w_br_cmp;
   always_comb begin
      w_br_cmp = 1'b0;
      case (w_f3)
         3'b000:  w_br_cmp = (w_a_v == w_b_v);
         3'b001:  w_br_cmp = (w_a_v != w_b_v);
         3'b100:  w_br_cmp = ($signed(w_a_v) <  $signed(w_b_v));
         3'b101:  w_br_cmp = ($signed(w_a_v) >= $signed(w_b_v));
         3'b110:  w_br_cmp = (w_a_v <  w_b_v);
         3'b111:  w_br_cmp = (w_a_v >= w_b_v);
         default: w_br_cmp = 1'b0;
      endcase
   end

   logic [31:0] w_pd_v, w_target, w_next_pc;
   logic        w_taken;
   always_comb begin
      w_pd_v   = '0;
      w_taken  = 1'b0;
      w_target = w_pc_4;
      case (w_opc)
         OP_LUI:         w_pd_v = w_u_imm;
         OP_AUIPC:       w_pd_v = w_pc + w_u_imm;
         OP_IMM, OP_REG: w_pd_v = w_alu;
         OP_JAL: begin
            w_pd_v   = w_pc_4;
            w_target = w_pc + w_j_imm;
            w_taken  = 1'b1;
         end
         OP_JALR: begin
            w_pd_v   = w_pc_4;
            w_target = (w_a_v + w_i_imm) & ~32'd1;
            w_taken  = 1'b1;
         end
         OP_BR: begin
            w_target = w_pc + w_b_imm;
            w_taken  = w_br_cmp;
         end
         default: ;
      endcase
   end

   // Result record is already in output_data layout so the queue head drives the port directly.
   logic [RES_W-1:0] w_res;
   assign w_next_pc = w_taken ? w_target : w_pc_4;
   assign w_res = {w_pd_s, w_rob, w_pd_v, w_order, w_pd_v, w_next_pc,
                   w_taken != w_pred, w_next_pc, w_pc, w_opc == OP_BR, w_taken};

   logic             w_flush, w_accept, w_push, w_pop;
   logic [RES_W-1:0] w_push_dat;
   logic [CNT_W:0]   w_pipe_occ, w_occ;
   assign w_flush  = rst | branch_mispredict;
   assign w_accept = fu_start & ~fu_busy;

   if (LAT == 1) begin : g_direct
      assign w_push     = w_accept;
      assign w_push_dat = w_res;
      assign w_pipe_occ = '0;
   end else begin : g_pipe
      logic [LAT-2:0]   r_vld;
      logic [RES_W-1:0] r_dat [LAT-1];
      always_ff @(posedge clk) begin
         if (w_flush) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < LAT - 1; i++) r_vld[i] <= r_vld[i-1];
         end
      end
      always_ff @(posedge clk) begin
         r_dat[0] <= w_res;
         for (int i = 1; i < LAT - 1; i++) r_dat[i] <= r_dat[i-1];
      end
      always_comb begin
         w_pipe_occ = '0;
         for (int i = 0; i < LAT - 1; i++) w_pipe_occ = w_pipe_occ + (CNT_W+1)'(r_vld[i]);
      end
      assign w_push     = r_vld[LAT-2];
      assign w_push_dat = r_dat[LAT-2];
   end

   logic [RES_W-1:0] r_q [OBUF_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0] r_cnt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fu_done = (r_cnt != '0);
   assign w_pop   = cdb_ack & fu_done;
   // Busy depends only on registered occupancy, keeping ack/start off the issue timing path.
   assign w_occ   = {1'b0, r_cnt} + w_pipe_occ;
   assign fu_busy = (w_occ >= (CNT_W+1)'(OBUF_DEPTH));

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_q[r_wr_ptr] <= w_push_dat;
   end

   logic [RES_W-1:0] w_head;
   assign w_head      = r_q[r_rd_ptr];
   assign output_data = {w_head[205:67], w_head[66] & fu_done, w_head[65:1], w_head[0] & fu_done};

endmodule
